input_register: RTL and testbench
=================================

Name: input_register

Overview:
- Front-panel input port for the 8-bit bus computer; the counterpart of the output register.
- The output register moves bus data out to the 7-segment display. This block moves operator data in: it samples 8 data switches when a debounced ENTER button is pressed.
- It holds the captured byte with a ready flag and drives it onto the shared tri-state bus when the control logic asserts output_en.

Parameters:
- DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples needed before the debounced ENTER level changes. Legal range 1..65535; counter width is derived from it.
- DATA_WIDTH, default 8: width of the bus, the switches and the data register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- switches  input  DATA_WIDTH  asynchronous operator data switches.
- enter_btn  input  1  asynchronous, bouncy ENTER push-button; active high.
- output_en  input  1  control word bit; when high, the block drives the bus and consumes the byte.
- bus  inout  DATA_WIDTH  shared system bus; high-Z unless driving.
- data_ready  output  1  a captured byte is waiting and has not yet been read.
- overrun  output  1  sticky; a new byte overwrote an unread byte.

Behaviour:
- Reset: on a clk edge with clear=1, all of the following go to 0:
  - both synchronizer stages (switches and enter_btn)
  - debounce counter and debounced level
  - data register, data_ready, overrun
  - clear has priority over every other event on that edge.
- Bus drive (combinational): bus = data register when output_en=1 and clear=0, otherwise all Z. No added latency.
- Synchronization: 2-flop synchronizer on enter_btn and on every switches bit. Capture uses the second-stage switches value.
- Debounce:
  - Counter resets to 0 whenever the synchronized ENTER equals the debounced level.
  - While they differ, the counter increments each cycle.
  - When a mismatch has been seen on DEBOUNCE_CYCLES consecutive edges, the debounced level flips on that edge and the counter returns to 0.
  - Pulses or bounces shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
- Capture: on the edge where the debounced level goes 0->1:
  - data register <= synchronized switches;
  - data_ready <= 1.
- Falling debounced edges capture nothing.
- Latency: with enter_btn held high from before edge 1, data_ready and the new data are visible after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- Read: on any edge with output_en=1 and no capture, data_ready <= 0. The consumer latches the bus on that same edge.
- Read while data_ready=0: the bus carries the stale (or reset-zero) data; no flag changes.
- Capture while data_ready=1 and output_en=0: data is overwritten, data_ready stays 1, overrun <= 1.
- Capture and read on the same edge:
  - the bus shows the old byte that cycle;
  - the new byte is stored and data_ready stays 1;
  - overrun is not set.
- overrun clears only via clear.
- Reset mid-debounce or mid-hold: all state zeroes. If the button is still held after clear drops, it is seen as a fresh press and captures again after DEBOUNCE_CYCLES+2 edges.
- Holding ENTER produces exactly one capture. Release must also be debounced before another press registers.

Decomposition:
- Shared package:
  - DATA_WIDTH default constant (8);
  - DEBOUNCE_CYCLES default;
  - clog2-style helper for the counter width.
- Sub-module button_debounce (clk, clear, raw, level, rise): holds the 2-flop sync, the counter and the level register, and emits a one-cycle rise pulse.
- The switch synchronizer and the data/flag logic stay in the top module.

Test Plan:
- Reset: clear=1 for 2 edges with output_en=0 -> bus=8'bz, data_ready=0, overrun=0. With output_en=1 -> bus=8'h00.
- Clean press: switches=8'd118, enter_btn held high -> data_ready rises after edge 6; then output_en=1 for one cycle -> bus=8'd118 that cycle; data_ready=0 after the edge; bus=Z after output_en drops.
- Bounce rejection: enter_btn pulses high 2 cycles / low 2 cycles five times, then steady high -> exactly one capture, after 6 edges of steady high; overrun=0.
- Overrun: capture 8'hCD, release and debounce, then press again with switches=8'h3A and no read -> overrun=1, data_ready=1, read gives 8'h3A.
- Simultaneous: output_en=1 on the exact capture edge of a second byte 8'h55 -> bus shows the old byte that cycle; afterwards data_ready=1, overrun=0, next read gives 8'h55.
- Reset mid-debounce: clear=1 at edge 4 of a held press -> no data_ready at edge 6; data_ready rises 6 edges after clear deasserts; data equals the switches value at that time.

Source files
------------

// File: rtl/input_register_pkg.sv
// Shared definitions for the front-panel input register.
//   DEFAULT_DATA_WIDTH      - default width of bus, switches and data register
//   DEFAULT_DEBOUNCE_CYCLES - default number of stable samples before ENTER flips
//   counter_width()         - width needed to count 0 .. max_count-1 (at least 1)
package input_register_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Smallest width that holds max_count-1; never returns 0 so a
    // DEBOUNCE_CYCLES of 1 still yields a legal one-bit counter.
    function automatic int counter_width(input int max_count);
        int w;
        w = 1;
        while ((1 << w) < max_count) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one asynchronous push-button.
//   clk   - system clock
//   clear - synchronous active-high reset
//   raw   - asynchronous, bouncy button input
//   level - debounced button level
//   rise  - one-cycle strobe, high during the cycle whose rising edge
//           moves level from 0 to 1 (combinational, so the consumer
//           acts on the same edge that flips level)
module button_debounce
    import input_register_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W    = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic mismatch;
    logic expire;

    assign mismatch = (sync2_reg != level_reg);
    // cnt_reg holds the number of mismatching edges already seen, so the
    // current edge is the DEBOUNCE_CYCLES-th one when it equals CNT_LAST.
    assign expire   = mismatch && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (!mismatch) begin
                cnt_reg <= '0;
            end else if (expire) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level = level_reg;
    assign rise  = expire && sync2_reg;

endmodule

// File: rtl/input_register.sv
// Front-panel input port: captures the data switches on a debounced ENTER
// press and drives the captured byte onto the shared tri-state bus.
//   clk        - system clock
//   clear      - synchronous active-high reset
//   switches   - asynchronous operator data switches
//   enter_btn  - asynchronous, bouncy ENTER button (active high)
//   output_en  - drive the bus with the held byte and consume it
//   bus        - shared system bus, high-Z unless output_en
//   data_ready - a captured byte has not been read yet
//   overrun    - sticky: a capture overwrote an unread byte
module input_register
    import input_register_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] switches,
    input  logic                  enter_btn,
    input  logic                  output_en,
    inout  wire  [DATA_WIDTH-1:0] bus,
    output logic                  data_ready,
    output logic                  overrun
);

    logic [DATA_WIDTH-1:0] sw_sync1_reg;
    logic [DATA_WIDTH-1:0] sw_sync2_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  data_ready_reg;
    logic                  overrun_reg;

    logic enter_level;
    logic enter_rise;
    logic capture;

    // Per-bit two-flop synchronizers for the switches. The bits are not
    // coherent with each other while an operator is flipping them; the
    // debounce delay on ENTER gives them time to settle before capture.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_sw_sync
            always_ff @(posedge clk) begin
                if (clear) begin
                    sw_sync1_reg[gi] <= 1'b0;
                    sw_sync2_reg[gi] <= 1'b0;
                end else begin
                    sw_sync1_reg[gi] <= switches[gi];
                    sw_sync2_reg[gi] <= sw_sync1_reg[gi];
                end
            end
        end
    endgenerate

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_debounce (
        .clk  (clk),
        .clear(clear),
        .raw  (enter_btn),
        .level(enter_level),
        .rise (enter_rise)
    );

    // A rise only happens while the debounced level is still low; the
    // level term keeps that relationship explicit at the capture point.
    assign capture = enter_rise && !enter_level;

    always_ff @(posedge clk) begin
        if (clear) begin
            data_reg       <= '0;
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (capture) begin
            data_reg       <= sw_sync2_reg;
            data_ready_reg <= 1'b1;
            // A same-edge read consumes the old byte, so nothing is lost.
            if (data_ready_reg && !output_en) begin
                overrun_reg <= 1'b1;
            end
        end else if (output_en) begin
            data_ready_reg <= 1'b0;
        end
    end

    assign bus        = (output_en && !clear) ? data_reg : {DATA_WIDTH{1'bz}};
    assign data_ready = data_ready_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_input_register.sv
// Directed self-checking bench for input_register (default parameters).
module tb_input_register;

    logic       clk;
    logic       clear;
    logic [7:0] switches;
    logic       enter_btn;
    logic       output_en;
    wire  [7:0] bus;
    logic       data_ready;
    logic       overrun;

    // Bench-side bus driver used to prove the DUT has released the bus:
    // with the DUT floating, the bus reads back exactly this pattern.
    logic       tb_drive;
    localparam logic [7:0] FLOAT_PATTERN = 8'hA5;
    assign bus = tb_drive ? FLOAT_PATTERN : 8'bz;

    int check_count;
    int error_count;

    input_register dut (
        .clk       (clk),
        .clear     (clear),
        .switches  (switches),
        .enter_btn (enter_btn),
        .output_en (output_en),
        .bus       (bus),
        .data_ready(data_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_float(input string tag);
        tb_drive = 1'b1;
        #1;
        check_value(tag, {24'd0, bus}, {24'd0, FLOAT_PATTERN});
        tb_drive = 1'b0;
        #1;
    endtask

    // One-cycle read: check the bus value, then the flag after the edge.
    task automatic read_byte(input string tag, input logic [7:0] exp);
        output_en = 1'b1;
        #1;
        check_value(tag, {24'd0, bus}, {24'd0, exp});
        tick(1);
        output_en = 1'b0;
        #1;
        check_value({tag, "_ready_after"}, {31'd0, data_ready}, 32'd0);
    endtask

    // Release ENTER and give the release time to be debounced.
    task automatic release_enter();
        enter_btn = 1'b0;
        tick(8);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        tb_drive    = 1'b0;
        clear       = 1'b1;
        switches    = 8'h00;
        enter_btn   = 1'b0;
        output_en   = 1'b0;

        // Reset
        tick(2);
        check_value("rst_ready", {31'd0, data_ready}, 32'd0);
        check_value("rst_overrun", {31'd0, overrun}, 32'd0);
        check_float("rst_bus_z");
        clear     = 1'b0;
        output_en = 1'b1;
        #1;
        check_value("rst_bus_zero", {24'd0, bus}, 32'h00);
        tick(1);
        output_en = 1'b0;
        #1;
        check_value("idle_read_ready", {31'd0, data_ready}, 32'd0);

        // Clean press: capture visible after edge 6, not edge 5
        switches  = 8'd118;
        enter_btn = 1'b1;
        tick(5);
        check_value("clean_ready_e5", {31'd0, data_ready}, 32'd0);
        tick(1);
        check_value("clean_ready_e6", {31'd0, data_ready}, 32'd1);
        check_value("clean_overrun", {31'd0, overrun}, 32'd0);
        read_byte("clean_bus", 8'd118);
        check_float("clean_bus_z");
        tick(4);
        check_value("clean_hold_single", {31'd0, data_ready}, 32'd0);
        release_enter();

        // Bounce rejection: 2 high / 2 low five times, then steady high
        switches = 8'h99;
        for (int b = 0; b < 5; b++) begin
            enter_btn = 1'b1;
            tick(2);
            enter_btn = 1'b0;
            tick(2);
        end
        check_value("bounce_ignored", {31'd0, data_ready}, 32'd0);
        enter_btn = 1'b1;
        tick(5);
        check_value("bounce_ready_e5", {31'd0, data_ready}, 32'd0);
        tick(1);
        check_value("bounce_ready_e6", {31'd0, data_ready}, 32'd1);
        check_value("bounce_overrun", {31'd0, overrun}, 32'd0);
        read_byte("bounce_bus", 8'h99);
        release_enter();

        // Overrun: second capture with no read in between
        switches  = 8'hCD;
        enter_btn = 1'b1;
        tick(6);
        check_value("ovr_first_ready", {31'd0, data_ready}, 32'd1);
        release_enter();
        check_value("ovr_release_ready", {31'd0, data_ready}, 32'd1);
        switches  = 8'h3A;
        enter_btn = 1'b1;
        tick(6);
        check_value("ovr_overrun", {31'd0, overrun}, 32'd1);
        check_value("ovr_ready", {31'd0, data_ready}, 32'd1);
        read_byte("ovr_bus", 8'h3A);
        check_value("ovr_sticky", {31'd0, overrun}, 32'd1);
        release_enter();

        // Clear the sticky overrun before the simultaneous case
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        #1;
        check_value("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Simultaneous capture and read
        switches  = 8'h11;
        enter_btn = 1'b1;
        tick(6);
        check_value("sim_first_ready", {31'd0, data_ready}, 32'd1);
        release_enter();
        switches  = 8'h55;
        enter_btn = 1'b1;
        tick(5);
        output_en = 1'b1;
        #1;
        check_value("sim_bus_old", {24'd0, bus}, 32'h11);
        tick(1);
        output_en = 1'b0;
        #1;
        check_value("sim_ready", {31'd0, data_ready}, 32'd1);
        check_value("sim_overrun", {31'd0, overrun}, 32'd0);
        read_byte("sim_bus_new", 8'h55);
        release_enter();

        // Reset in the middle of a held press
        switches  = 8'h42;
        enter_btn = 1'b1;
        tick(3);
        clear = 1'b1;
        tick(1);
        clear    = 1'b0;
        switches = 8'h24;
        tick(2);
        check_value("midrst_no_ready_e6", {31'd0, data_ready}, 32'd0);
        tick(3);
        check_value("midrst_ready_5", {31'd0, data_ready}, 32'd0);
        tick(1);
        check_value("midrst_ready_6", {31'd0, data_ready}, 32'd1);
        check_value("midrst_overrun", {31'd0, overrun}, 32'd0);
        read_byte("midrst_bus", 8'h24);
        release_enter();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
